// File: rtl/step_counter_pkg.sv
// Shared types and helpers for the push-button step counter and its BCD display path.
package step_counter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } conv_state_e;

    typedef logic [3:0] bcd_digit_t;

    // Number of decimal digits needed to show 2**width-1.
    function automatic int unsigned bcd_digits_for(input int unsigned width);
        longint unsigned max_val;
        int unsigned     n;
        max_val = (64'd1 << width) - 64'd1;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (max_val >= 64'd10) begin
                max_val = max_val / 64'd10;
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Converts whenever value_i differs from the last loaded value (or start_i); bcd_o updates atomically.
module bin2bcd_seq
    import step_counter_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      value_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  valid_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    conv_state_e          state_q, state_d;
    logic [WIDTH-1:0]     value_q, value_d;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic [4*DIGITS-1:0]  scratch_q, scratch_d;
    logic [4*DIGITS-1:0]  adjusted;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 value_changed;

    assign value_changed = (value_i != value_q);

    always_comb begin
        adjusted = scratch_q;
        for (int d = 0; d < int'(DIGITS); d++) begin
            bcd_digit_t digit;
            digit = scratch_q[4*d +: 4];
            if (digit >= 4'd5) begin
                adjusted[4*d +: 4] = digit + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        valid_d   = valid_q;
        case (state_q)
            StIdle: begin
                if (start_i || value_changed) begin
                    state_d   = StShift;
                    value_d   = value_i;
                    bin_d     = value_i;
                    scratch_d = '0;
                    cnt_d     = '0;
                    valid_d   = 1'b0;
                end
            end
            StShift, StDone: begin
                // A new value mid-conversion restarts it; bcd_q is never touched until DONE.
                if (value_changed) begin
                    state_d   = StShift;
                    value_d   = value_i;
                    bin_d     = value_i;
                    scratch_d = '0;
                    cnt_d     = '0;
                    valid_d   = 1'b0;
                end else if (state_q == StShift) begin
                    {scratch_d, bin_d} = {adjusted[4*DIGITS-2:0], bin_q, 1'b0};
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d = StDone;
                    end
                end else begin
                    bcd_d   = scratch_q;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            value_q   <= '0;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            valid_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
        end
    end

    assign bcd_o   = bcd_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/step_counter_bcd.sv
// Push-button step counter (up/down, saturate/wrap) with sequential BCD output.
// Define STEP_COUNTER_DEBOUNCE_EN to insert the debounce filter after the synchroniser.
module step_counter_bcd
    import step_counter_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned STEP            = 10,
    parameter int unsigned LIMIT           = 150,
    parameter int unsigned DIGITS          = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  button_i,
    input  logic                  enable_i,
    input  logic                  dir_i,
    output logic [WIDTH-1:0]      count_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  bcd_valid_o,
    output logic                  wrap_o
);

    if (64'(LIMIT) >= (64'd1 << WIDTH)) begin : g_chk_limit
        $error("LIMIT must be below 2**WIDTH");
    end
    if (STEP < 1 || STEP > LIMIT) begin : g_chk_step
        $error("STEP must be in 1..LIMIT");
    end
    if (bcd_digits_for(WIDTH) > DIGITS) begin : g_chk_digits
        $error("DIGITS too small for WIDTH");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    localparam logic [WIDTH-1:0] StepN  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] LimitN = WIDTH'(LIMIT);
    localparam logic [WIDTH:0]   StepX  = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0]   LimitX = (WIDTH + 1)'(LIMIT);

    logic [1:0] sync_q, sync_d;
    logic [1:0] fill_q, fill_d;
    logic       armed_q, armed_d;
    logic       level_prev_q, level_prev_d;
    logic       press_q, press_d;
    logic       level;

`ifdef STEP_COUNTER_DEBOUNCE_EN
    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           level_q, level_d;

    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (sync_q[1] != level_q) begin
            if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt_q <= '0;
            level_q  <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
        end
    end

    assign level = level_q;
`else
    assign level = sync_q[1];
`endif

    // Edges are only honoured once the button has been seen released after reset,
    // so a button held through reset does not count as a press.
    always_comb begin
        sync_d       = {sync_q[0], button_i};
        fill_d       = {fill_q[0], 1'b1};
        armed_d      = armed_q | (fill_q[1] & ~sync_q[1]);
        level_prev_d = level;
        press_d      = armed_q & level & ~level_prev_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q       <= '0;
            fill_q       <= '0;
            armed_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            fill_q       <= fill_d;
            armed_q      <= armed_d;
            level_prev_q <= level_prev_d;
            press_q      <= press_d;
        end
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        sum     = {1'b0, count_q} + StepX;
        if (!enable_i) begin
            count_d = '0;
        end else if (press_q) begin
            if (!dir_i) begin
                if (count_q == LimitN) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else if (sum > LimitX) begin
                    count_d = LimitN;
                end else begin
                    count_d = sum[WIDTH-1:0];
                end
            end else begin
                if (count_q == '0) begin
                    count_d = LimitN;
                    wrap_d  = 1'b1;
                end else if ({1'b0, count_q} < StepX) begin
                    count_d = '0;
                end else begin
                    count_d = count_q - StepN;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .start_i (1'b0),
        .value_i (count_q),
        .bcd_o   (bcd_o),
        .valid_o (bcd_valid_o)
    );

endmodule
